// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment capture block: glyph table, blank pattern, defaults.
package seg7_pkg;

  localparam int unsigned DEFAULT_DIGITS        = 4;
  localparam int unsigned DEFAULT_STABLE_CYCLES = 4;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned NUM_GLYPHS = 16;

  // Active-low segment patterns, bit6 = middle ... bit0 = top.
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] GLYPH_0   = 7'b1000000;
  localparam logic [SEG_W-1:0] GLYPH_1   = 7'b1111001;
  localparam logic [SEG_W-1:0] GLYPH_2   = 7'b0100100;
  localparam logic [SEG_W-1:0] GLYPH_3   = 7'b0110000;
  localparam logic [SEG_W-1:0] GLYPH_4   = 7'b0011001;
  localparam logic [SEG_W-1:0] GLYPH_5   = 7'b0010010;
  localparam logic [SEG_W-1:0] GLYPH_6   = 7'b0000010;
  localparam logic [SEG_W-1:0] GLYPH_7   = 7'b1111000;
  localparam logic [SEG_W-1:0] GLYPH_8   = 7'b0000000;
  localparam logic [SEG_W-1:0] GLYPH_9   = 7'b0010000;
  localparam logic [SEG_W-1:0] GLYPH_A   = 7'b0001000;
  localparam logic [SEG_W-1:0] GLYPH_B   = 7'b0000011;
  localparam logic [SEG_W-1:0] GLYPH_C   = 7'b1000110;
  localparam logic [SEG_W-1:0] GLYPH_D   = 7'b0100001;
  localparam logic [SEG_W-1:0] GLYPH_E   = 7'b0000110;
  localparam logic [SEG_W-1:0] GLYPH_F   = 7'b0001110;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_COUNT = 2'd1,
    ST_HELD  = 2'd2
  } cap_state_e;

  // Nibble to segment pattern; the same table drives the hex-to-segment encoder.
  function automatic logic [SEG_W-1:0] glyph_of(input logic [NIB_W-1:0] nib);
    logic [SEG_W-1:0] g;
    case (nib)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = GLYPH_A;
      4'hB:    g = GLYPH_B;
      4'hC:    g = GLYPH_C;
      4'hD:    g = GLYPH_D;
      4'hE:    g = GLYPH_E;
      default: g = GLYPH_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Segment pattern to hex nibble decoder; unknown patterns give nibble 0 with err set.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_n,
  output logic [NIB_W-1:0] nibble,
  output logic             err
);

  // Search the glyph table; patterns are unique so at most one entry matches.
  always_comb begin
    nibble = '0;
    err    = 1'b1;
    for (int unsigned i = 0; i < NUM_GLYPHS; i++) begin
      if (seg_n == glyph_of(NIB_W'(i))) begin
        nibble = NIB_W'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed seven-segment display scan into per-slot hex nibbles.
// Each slot is written once its strobe/segment pattern has been stable long enough.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = DEFAULT_DIGITS,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SEG_W-1:0]        seg_n,
  input  logic [DIGITS-1:0]       an_n,
  output logic [NIB_W*DIGITS-1:0] digits,
  output logic [DIGITS-1:0]       digit_err,
  output logic                    frame_valid,
  output logic                    strobe_err
);

  localparam int unsigned SMP_W = DIGITS + SEG_W;
  localparam int unsigned LOW_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);

  logic [SEG_W-1:0]  seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [DIGITS-1:0] an_s1_q, an_s1_d, an_s2_q, an_s2_d;
  logic [SMP_W-1:0]  prev_q, prev_d;

  cap_state_e        state_q, state_d;
  logic [CNT_W-1:0]  counter_q, counter_d;

  logic [DIGITS-1:0]             mask_q, mask_d;
  logic [DIGITS-1:0][NIB_W-1:0]  shadow_nib_q, shadow_nib_d;
  logic [DIGITS-1:0]             shadow_err_q, shadow_err_d;
  logic [DIGITS-1:0][NIB_W-1:0]  digits_q, digits_d;
  logic [DIGITS-1:0]             digit_err_q, digit_err_d;
  logic                          frame_valid_q, frame_valid_d;
  logic                          strobe_err_q, strobe_err_d;

  logic [SMP_W-1:0]  sample_c;
  logic              changed_c;
  logic              capture_c;
  logic [DIGITS-1:0] cap_an_c;
  logic [DIGITS-1:0] an_low_c;
  logic [SEG_W-1:0]  cap_seg_c;
  logic [LOW_W-1:0]  low_cnt_c;
  logic [NIB_W-1:0]  dec_nib_c;
  logic              dec_err_c;

  // Two-flop synchronizer and previous-sample register.
  always_comb begin
    seg_s1_d  = seg_n;
    seg_s2_d  = seg_s1_q;
    an_s1_d   = an_n;
    an_s2_d   = an_s1_q;
    sample_c  = {an_s2_q, seg_s2_q};
    prev_d    = sample_c;
    changed_c = (sample_c != prev_q);
    cap_an_c  = prev_q[SMP_W-1:SEG_W];
    cap_seg_c = prev_q[SEG_W-1:0];
  end

  seg7_decode u_decode (
    .seg_n  (cap_seg_c),
    .nibble (dec_nib_c),
    .err    (dec_err_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_WAIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Stability FSM; capture fires once the held sample has been seen STABLE_CYCLES times.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    capture_c = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (changed_c) begin
          state_d   = ST_COUNT;
          counter_d = CNT_W'(1);
        end
      end
      ST_COUNT: begin
        if (counter_q >= STABLE_LIM) begin
          capture_c = 1'b1;
          if (changed_c) begin
            counter_d = CNT_W'(1);
          end else begin
            state_d = ST_HELD;
          end
        end else if (changed_c) begin
          counter_d = CNT_W'(1);
        end else if (counter_q != '1) begin
          counter_d = counter_q + CNT_W'(1);
        end
      end
      ST_HELD: begin
        if (changed_c) begin
          state_d   = ST_COUNT;
          counter_d = CNT_W'(1);
        end
      end
      default: begin
        state_d   = ST_WAIT;
        counter_d = '0;
      end
    endcase
  end

  // Count active strobes in the captured sample.
  always_comb begin
    an_low_c  = ~cap_an_c;
    low_cnt_c = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (an_low_c[i]) begin
        low_cnt_c = low_cnt_c + LOW_W'(1);
      end
    end
  end

  // Shadow write, frame publish and strobe error tracking.
  always_comb begin
    mask_d        = mask_q;
    shadow_nib_d  = shadow_nib_q;
    shadow_err_d  = shadow_err_q;
    digits_d      = digits_q;
    digit_err_d   = digit_err_q;
    frame_valid_d = 1'b0;
    strobe_err_d  = strobe_err_q;

    if (mask_q == '1) begin
      digits_d      = shadow_nib_q;
      digit_err_d   = shadow_err_q;
      frame_valid_d = 1'b1;
      mask_d        = '0;
    end

    if (capture_c) begin
      if (low_cnt_c == LOW_W'(1)) begin
        for (int unsigned i = 0; i < DIGITS; i++) begin
          if (an_low_c[i]) begin
            shadow_nib_d[i] = dec_nib_c;
            shadow_err_d[i] = dec_err_c;
            mask_d[i]       = 1'b1;
          end
        end
      end else if (low_cnt_c > LOW_W'(1)) begin
        strobe_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s1_q      <= SEG_BLANK;
      seg_s2_q      <= SEG_BLANK;
      an_s1_q       <= '1;
      an_s2_q       <= '1;
      prev_q        <= '1;
      counter_q     <= '0;
      mask_q        <= '0;
      shadow_nib_q  <= '0;
      shadow_err_q  <= '0;
      digits_q      <= '0;
      digit_err_q   <= '0;
      frame_valid_q <= 1'b0;
      strobe_err_q  <= 1'b0;
    end else begin
      seg_s1_q      <= seg_s1_d;
      seg_s2_q      <= seg_s2_d;
      an_s1_q       <= an_s1_d;
      an_s2_q       <= an_s2_d;
      prev_q        <= prev_d;
      counter_q     <= counter_d;
      mask_q        <= mask_d;
      shadow_nib_q  <= shadow_nib_d;
      shadow_err_q  <= shadow_err_d;
      digits_q      <= digits_d;
      digit_err_q   <= digit_err_d;
      frame_valid_q <= frame_valid_d;
      strobe_err_q  <= strobe_err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_err   = digit_err_q;
  assign frame_valid = frame_valid_q;
  assign strobe_err  = strobe_err_q;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed testbench for seg7_capture with hand-computed expected frames.
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [6:0]  seg_n = 7'h7F;
  logic [3:0]  an_n = 4'hF;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        strobe_err;

  int errors = 0;
  int checks = 0;

  int          fv_count = 0;
  int          fv_b2b = 0;
  int          dig_glitch = 0;
  logic        fv_prev = 1'b0;
  logic [15:0] dig_prev = '0;
  logic [3:0]  derr_prev = '0;

  seg7_capture #(
    .DIGITS        (4),
    .STABLE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .digits      (digits),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .strobe_err  (strobe_err)
  );

  always #5 clk = ~clk;

  // Track frame pulses, back-to-back pulses and output changes outside a frame pulse.
  always @(negedge clk) begin
    if (frame_valid) fv_count++;
    if (frame_valid && fv_prev) fv_b2b++;
    if (!frame_valid && !reset && (digits !== dig_prev || digit_err !== derr_prev)) dig_glitch++;
    fv_prev   = frame_valid;
    dig_prev  = digits;
    derr_prev = digit_err;
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    an_n  = 4'hF;
    seg_n = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL reset_digits got=%h exp=%h", digits, 16'h0000); end
    checks++; if (digit_err !== 4'h0) begin errors++; $display("FAIL reset_digit_err got=%b exp=%b", digit_err, 4'h0); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid got=%b exp=0", frame_valid); end
    checks++; if (strobe_err !== 1'b0) begin errors++; $display("FAIL reset_strobe_err got=%b exp=0", strobe_err); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_scan();
    int fv0 = fv_count;
    int lat = 0;
    drive(4'b1110, 7'b0110000, 8);
    drive(4'b1101, 7'b0001000, 8);
    drive(4'b1011, 7'b1000000, 8);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL scan_early_frame got=%0d exp=0", fv_count - fv0); end
    an_n  = 4'b0111;
    seg_n = 7'b0001110;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (frame_valid && lat == 0) lat = k;
    end
    @(posedge clk);
    #1;
    checks++; if (lat !== 8) begin errors++; $display("FAIL scan_latency got=%0d exp=8", lat); end
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL scan_frames got=%0d exp=1", fv_count - fv0); end
    checks++; if (digits !== 16'hF0A3) begin errors++; $display("FAIL scan_digits got=%h exp=%h", digits, 16'hF0A3); end
    checks++; if (digit_err !== 4'b0000) begin errors++; $display("FAIL scan_digit_err got=%b exp=%b", digit_err, 4'b0000); end
  endtask

  task automatic test_bad_glyph();
    int fv0 = fv_count;
    drive(4'b1110, 7'b1111001, 8);
    drive(4'b1101, 7'b1111111, 8);
    drive(4'b1011, 7'b0100100, 8);
    drive(4'b0111, 7'b0000110, 8);
    drive(4'hF, 7'h7F, 6);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL bad_glyph_frames got=%0d exp=1", fv_count - fv0); end
    checks++; if (digits !== 16'hE201) begin errors++; $display("FAIL bad_glyph_digits got=%h exp=%h", digits, 16'hE201); end
    checks++; if (digit_err !== 4'b0010) begin errors++; $display("FAIL bad_glyph_err got=%b exp=%b", digit_err, 4'b0010); end
  endtask

  task automatic test_toggle();
    int fv0 = fv_count;
    for (int i = 0; i < 20; i++) begin
      drive(4'b1110, ((i % 2) != 0) ? 7'b0010010 : 7'b0110000, 2);
    end
    drive(4'b1101, 7'b0000000, 8);
    drive(4'b1011, 7'b0000011, 8);
    drive(4'b0111, 7'b1000110, 8);
    drive(4'hF, 7'h7F, 6);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL toggle_no_frame got=%0d exp=0", fv_count - fv0); end
    drive(4'b1110, 7'b1111000, 8);
    drive(4'hF, 7'h7F, 6);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL toggle_frames got=%0d exp=1", fv_count - fv0); end
    checks++; if (digits !== 16'hCB87) begin errors++; $display("FAIL toggle_digits got=%h exp=%h", digits, 16'hCB87); end
    checks++; if (digit_err !== 4'b0000) begin errors++; $display("FAIL toggle_err got=%b exp=%b", digit_err, 4'b0000); end
  endtask

  task automatic test_strobe();
    int fv0 = fv_count;
    checks++; if (strobe_err !== 1'b0) begin errors++; $display("FAIL strobe_pre got=%b exp=0", strobe_err); end
    drive(4'b1100, 7'b0010010, 8);
    drive(4'hF, 7'h7F, 4);
    checks++; if (strobe_err !== 1'b1) begin errors++; $display("FAIL strobe_set got=%b exp=1", strobe_err); end
    drive(4'b1101, 7'b0011001, 8);
    drive(4'b1011, 7'b0010000, 8);
    drive(4'b0111, 7'b0100001, 8);
    drive(4'hF, 7'h7F, 6);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL strobe_mask_untouched got=%0d exp=0", fv_count - fv0); end
    drive(4'b1110, 7'b0000010, 8);
    drive(4'hF, 7'h7F, 6);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL strobe_frames got=%0d exp=1", fv_count - fv0); end
    checks++; if (digits !== 16'hD946) begin errors++; $display("FAIL strobe_digits got=%h exp=%h", digits, 16'hD946); end
    checks++; if (strobe_err !== 1'b1) begin errors++; $display("FAIL strobe_sticky got=%b exp=1", strobe_err); end
  endtask

  task automatic test_reset_mid();
    int fv0 = fv_count;
    drive(4'b1110, 7'b1111001, 8);
    drive(4'b1101, 7'b0100100, 8);
    drive(4'hF, 7'h7F, 2);
    reset = 1'b1;
    drive(4'hF, 7'h7F, 2);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (digits !== 16'h0000) begin errors++; $display("FAIL midreset_digits got=%h exp=%h", digits, 16'h0000); end
    checks++; if (digit_err !== 4'h0) begin errors++; $display("FAIL midreset_err got=%b exp=%b", digit_err, 4'h0); end
    checks++; if (strobe_err !== 1'b0) begin errors++; $display("FAIL midreset_strobe got=%b exp=0", strobe_err); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL midreset_fv got=%b exp=0", frame_valid); end
    @(posedge clk);
    #1;
    fv0 = fv_count;
    drive(4'b1011, 7'b0000010, 8);
    drive(4'b0111, 7'b1111000, 8);
    drive(4'hF, 7'h7F, 6);
    checks++; if (fv_count - fv0 !== 0) begin errors++; $display("FAIL midreset_partial_discard got=%0d exp=0", fv_count - fv0); end
    drive(4'b1110, 7'b0011001, 8);
    drive(4'b1101, 7'b0010010, 8);
    drive(4'hF, 7'h7F, 6);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL midreset_frames got=%0d exp=1", fv_count - fv0); end
    checks++; if (digits !== 16'h7654) begin errors++; $display("FAIL midreset_digits_new got=%h exp=%h", digits, 16'h7654); end
  endtask

  task automatic test_saturate();
    int fv0 = fv_count;
    drive(4'b1110, 7'b0001000, 8);
    drive(4'b1101, 7'b0000011, 8);
    drive(4'b0111, 7'b0001110, 8);
    drive(4'b1011, 7'b0010000, 300);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL sat_frames got=%0d exp=1", fv_count - fv0); end
    checks++; if (digits !== 16'hF9BA) begin errors++; $display("FAIL sat_digits got=%h exp=%h", digits, 16'hF9BA); end
    drive(4'b1110, 7'b1000000, 8);
    drive(4'b1101, 7'b1111001, 8);
    drive(4'b0111, 7'b0110000, 8);
    drive(4'hF, 7'h7F, 6);
    checks++; if (fv_count - fv0 !== 1) begin errors++; $display("FAIL sat_no_repeat_write got=%0d exp=1", fv_count - fv0); end
    drive(4'b1011, 7'b0100100, 8);
    drive(4'hF, 7'h7F, 6);
    checks++; if (fv_count - fv0 !== 2) begin errors++; $display("FAIL sat_frames2 got=%0d exp=2", fv_count - fv0); end
    checks++; if (digits !== 16'h3210) begin errors++; $display("FAIL sat_digits2 got=%h exp=%h", digits, 16'h3210); end
  endtask

  task automatic test_back_to_back();
    checks++; if (fv_b2b !== 0) begin errors++; $display("FAIL fv_back_to_back got=%0d exp=0", fv_b2b); end
    checks++; if (dig_glitch !== 0) begin errors++; $display("FAIL digits_change_outside_frame got=%0d exp=0", dig_glitch); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_bad_glyph();
    test_toggle();
    test_strobe();
    test_reset_mid();
    test_saturate();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_capture.md
SEG7_CAPTURE -- requirements
Module: seg7_capture

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed digit positions captured.
REQ-002 Parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical synchronized samples required before capture.
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 seg_n  input  7  active-low segments; bit0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle.
REQ-006 an_n  input  DIGITS  active-low digit strobes; bit i selects digit slot i.
REQ-007 digits  output  4*DIGITS  captured nibbles; slot i at bits [4i+3:4i]; registered.
REQ-008 digit_err  output  DIGITS  per-slot flag; 1 = last captured pattern for that slot was not a legal hex glyph.
REQ-009 frame_valid  output  1  one-cycle pulse; digits/digit_err updated this cycle.
REQ-010 strobe_err  output  1  sticky; set when a stable sample has more than one an_n bit low.

Function
REQ-011 seg_n and an_n shall pass through a 2-flop synchronizer before any use.
REQ-012 Legal glyphs (seg_n, MSB=bit6): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-013 Any other seg_n value shall decode to nibble 0 with error=1.
REQ-014 FSM states: WAIT, COUNT, HELD.
REQ-015 WAIT: on any change of synchronized {an_n,seg_n} vs previous sample -> COUNT, counter=1.
REQ-016 COUNT: sample equal to previous increments counter; any change restarts counter at 1 (stays COUNT).
REQ-017 COUNT: when counter reaches STABLE_CYCLES -> HELD and perform exactly one capture action (REQ-019..021).
REQ-018 HELD: no further capture; any sample change -> COUNT, counter=1.
REQ-019 Capture with exactly one an_n bit low (slot i): write decoded nibble and error bit to shadow slot i; set written-mask bit i.
REQ-020 Capture with an_n all ones (blank): no write, no flag.
REQ-021 Capture with two or more an_n bits low: no write; set strobe_err.
REQ-022 Rewriting an already-written slot before frame completion shall overwrite the shadow value.
REQ-023 When written-mask becomes all ones, next cycle: copy shadow to digits/digit_err, pulse frame_valid, clear mask.
REQ-024 Latency: input settle at cycle t -> slot write at t+2+STABLE_CYCLES; frame_valid one cycle after the final slot write.
REQ-025 frame_valid shall never be high two consecutive cycles.
REQ-026 digits/digit_err shall change only in a frame_valid cycle.
REQ-027 Counter shall saturate; no wrap-around while input is static.

Reset
REQ-028 reset shall force: state WAIT, counter 0, mask 0, shadow 0, digits 0, digit_err 0, frame_valid 0, strobe_err 0.
REQ-029 Synchronizer and previous-sample registers shall reset to all ones (blank, no strobe).
REQ-030 reset mid-frame shall discard the partial frame; no frame_valid until a full new frame is captured.
REQ-031 strobe_err shall clear only on reset.

Structure
REQ-032 Shared package seg7_pkg shall hold the 16 glyph constants, blank pattern 7'b1111111, and default DIGITS/STABLE_CYCLES.
REQ-033 Combinational sub-module seg7_decode (seg_n[6:0] -> nibble[3:0], err) shall implement REQ-012/013; same glyph table as the team's hex-to-segment driver.
REQ-034 FSM, counter, mask, shadow and output registers reside in seg7_capture.

Verification
REQ-035 Scan digits 3,A,0,F (an_n 1110/1101/1011/0111, 8 cycles each) -> one frame_valid, digits=16'hF0A3, digit_err=0.
REQ-036 Slot1 glyph 1111111 (blank segments), others legal -> digit_err=4'b0010, slot1 nibble 0.
REQ-037 seg_n toggles every 2 cycles with STABLE_CYCLES=4 -> no capture, no frame_valid.
REQ-038 an_n=1100 held 8 cycles -> strobe_err=1, mask unchanged, then full scan still yields frame.
REQ-039 reset asserted after 2 of 4 slots written -> all outputs 0; next 4-slot scan gives exactly one frame_valid.
REQ-040 Stable glyph held 300 cycles -> single capture; counter saturates, no repeat write.
